// File: rtl/mo_inv_pkg.sv
// mo_inv_pkg: shared constants and types for the Montgomery-domain modular inverter
//   DATA_WIDTH : coefficient width
//   Q          : prime modulus (R = 2^MINV_W in the pairing mo_mul)
//   minv_state_e / minv_s : controller states and Kaliski working set {u, v, r, s}
package mo_inv_pkg;
  localparam int DATA_WIDTH = 12;
  localparam logic [DATA_WIDTH-1:0] Q = 12'd3329;
  typedef enum logic [2:0] {MINV_IDLE, MINV_P1, MINV_FIX, MINV_P2, MINV_DONE} minv_state_e;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] u;
    logic [DATA_WIDTH-1:0] v;
    logic [DATA_WIDTH:0]   r;
    logic [DATA_WIDTH:0]   s;
  } minv_s;
endpackage

// File: rtl/mo_inv_step.sv
// mo_inv_step: one combinational iteration of Kaliski's binary almost-inverse
//   st_i : current {u, v, r, s}
//   st_o : state after one iteration (caller only applies it while v != 0)
module mo_inv_step
  import mo_inv_pkg::*;
(
  input  minv_s st_i,
  output minv_s st_o
);
  always_comb begin
    st_o = st_i;
    if (!st_i.u[0]) begin
      st_o.u = st_i.u >> 1;
      st_o.s = st_i.s << 1;
    end else if (!st_i.v[0]) begin
      st_o.v = st_i.v >> 1;
      st_o.r = st_i.r << 1;
    end else if (st_i.u > st_i.v) begin
      st_o.u = (st_i.u - st_i.v) >> 1;
      st_o.r = st_i.r + st_i.s;
      st_o.s = st_i.s << 1;
    end else begin
      st_o.v = (st_i.v - st_i.u) >> 1;
      st_o.s = st_i.s + st_i.r;
      st_o.r = st_i.r << 1;
    end
  end
endmodule

// File: rtl/mo_inv.sv
// mo_inv: iterative Montgomery-domain inverter, result = a^-1 * R^2 mod Q with R = 2^MINV_W
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (ready only while idle)
//   a                    : operand 0..Q (Q aliases 0)
//   out_valid / out_ready: result handshake, result held until accepted
//   result, err          : inverse, and flag for a non-invertible operand
module mo_inv
  import mo_inv_pkg::*;
#(
  parameter int MINV_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  err
);
  localparam int KW = $clog2(2*MINV_W+1);
  localparam logic [KW-1:0] K_MAX = KW'(2*MINV_W);
  localparam logic [DATA_WIDTH:0] QX = {1'b0, Q};
  minv_state_e state_q;
  minv_s st_q, st_d;
  logic [KW-1:0] cnt_q;
  logic zero_q;
  logic [DATA_WIDTH:0] r_red, r_fix, r_dbl, r_dbl_d;
  mo_inv_step u_step (.st_i(st_q), .st_o(st_d));
  // phase 1 leaves r = -a^-1 * 2^k (mod Q) in [0, 2Q); FIX negates and reduces it
  assign r_red   = (st_q.r >= QX) ? st_q.r - QX : st_q.r;
  assign r_fix   = zero_q ? '0 : QX - r_red;
  assign r_dbl   = {st_q.r[DATA_WIDTH-1:0], 1'b0};
  assign r_dbl_d = (r_dbl >= QX) ? r_dbl - QX : r_dbl;
  assign in_ready = (state_q == MINV_IDLE);
  // cnt_q counts k during phase 1, then is reloaded with 2*MINV_W-k doublings for phase 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MINV_IDLE;
      st_q      <= '0;
      cnt_q     <= '0;
      zero_q    <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      err       <= 1'b0;
    end else begin
      case (state_q)
        MINV_IDLE: if (in_valid) begin
          st_q.u  <= Q;
          st_q.v  <= (a == Q) ? '0 : a;
          st_q.r  <= '0;
          st_q.s  <= (DATA_WIDTH+1)'(1);
          cnt_q   <= '0;
          zero_q  <= (a == Q) || (a == '0);
          state_q <= MINV_P1;
        end
        MINV_P1: if (st_q.v != '0) begin
          st_q  <= st_d;
          cnt_q <= cnt_q + KW'(1);
        end else begin
          state_q <= MINV_FIX;
        end
        MINV_FIX: begin
          st_q.r  <= r_fix;
          cnt_q   <= K_MAX - cnt_q;
          state_q <= MINV_P2;
        end
        MINV_P2: if (cnt_q != '0) begin
          st_q.r <= r_dbl_d;
          cnt_q  <= cnt_q - KW'(1);
        end else begin
          result    <= st_q.r[DATA_WIDTH-1:0];
          err       <= zero_q;
          out_valid <= 1'b1;
          state_q   <= MINV_DONE;
        end
        MINV_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state_q   <= MINV_IDLE;
        end
        default: state_q <= MINV_IDLE;
      endcase
    end
  end
  k_bound: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= K_MAX);
endmodule

// File: tb/tb_mo_inv.sv
// tb_mo_inv: directed and round-trip checks of mo_inv with Q=3329, MINV_W=12
module tb_mo_inv;
  import mo_inv_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [11:0] a = '0;
  logic in_ready, out_valid, err;
  logic [11:0] result;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  mo_inv #(.MINV_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .err(err)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic start(input int av);
    a = 12'(av);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask
  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
  int av_t[6] = '{767, 2385, 1, 3328, 0, 3329};
  int rs_t[6] = '{767, 1, 2385, 944, 0, 0};
  int er_t[6] = '{0, 0, 0, 0, 1, 1};
  initial begin
    int lat, av;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      start(av_t[i]);
      wait_done(lat);
      check($sformatf("res_a%0d", av_t[i]), result, rs_t[i]);
      check($sformatf("err_a%0d", av_t[i]), err, er_t[i]);
      check($sformatf("lat_a%0d", av_t[i]), lat, 27);
      ack();
      check($sformatf("idle_a%0d", av_t[i]), {out_valid, in_ready}, 1);
    end
    for (int i = 0; i < 1000; i++) begin
      av = int'($urandom_range(1, 3328));
      start(av);
      wait_done(lat);
      check("roundtrip", (av * int'(result)) % 3329, 2385);
      check("roundtrip_err", err, 0);
      ack();
    end
    start(767);
    wait_done(lat);
    check("bp_lat", lat, 27);
    a = 12'd5;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {out_valid, in_ready, err, result}, {1'b1, 1'b0, 1'b0, 12'd767});
    end
    in_valid = 1'b0;
    ack();
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    check("bp_no_start", in_ready, 1);
    start(2385);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    start(767);
    wait_done(lat);
    check("post_rst_res", result, 767);
    check("post_rst_lat", lat, 27);
    ack();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
